// File: rtl/gpio_input_debounce.sv
// rtl/gpio_input_debounce.sv - GPIO input synchroniser, debouncer and event-flag register block
// Optional feature macro: GPIO_DEBOUNCE_IRQ_EN (registered event-pending irq output)
module gpio_input_debounce #(
    parameter int N_IN            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic            bus_clk,
    input  logic            quiesce,
    input  logic [N_IN-1:0] pins_in,
    input  logic            rden,
    input  logic [4:0]      addr,
    output logic [7:0]      rd_data,
    output logic [N_IN-1:0] stable,
    output logic            irq
);

    // Terminal count: the cycle on which a persistent difference is accepted.
    localparam logic [CNT_W-1:0] L_CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       L_NIN_VALUE = {4'h0, 4'(N_IN)};

    logic [N_IN-1:0]  r_s1;
    logic [N_IN-1:0]  r_s2;
    logic [CNT_W-1:0] r_cnt [N_IN];
    logic [N_IN-1:0]  r_stable;
    logic [N_IN-1:0]  r_rise;
    logic [N_IN-1:0]  r_fall;
    logic [7:0]       r_rd_data;

    logic [CNT_W-1:0] w_cnt_nxt [N_IN];
    logic [N_IN-1:0]  w_stable_nxt;
    logic [N_IN-1:0]  w_rise_nxt;
    logic [N_IN-1:0]  w_fall_nxt;
    logic             w_clr_rise;
    logic             w_clr_fall;
    logic [7:0]       w_stable_ext;
    logic [7:0]       w_rise_ext;
    logic [7:0]       w_fall_ext;
    logic [7:0]       w_rd_mux;

    assign stable  = r_stable;
    assign rd_data = r_rd_data;

    // Two-flop synchroniser; only r_s2 is allowed to feed the debouncer.
    always_ff @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= pins_in;
            r_s2 <= r_s1;
        end
    end

    // Per-bit debounce: count consecutive disagreeing cycles, accept at terminal count.
    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < N_IN; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_s2[i] != r_stable[i]) begin
                if (r_cnt[i] == L_CNT_MAX) begin
                    w_stable_nxt[i] = r_s2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounce counters and accepted levels.
    always_ff @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) begin
            r_stable <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_nxt;
            for (int i = 0; i < N_IN; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Sticky flags: a read clears them, but an event in the same edge is kept.
    assign w_clr_rise = rden && (addr == 5'd1);
    assign w_clr_fall = rden && (addr == 5'd2);
    assign w_rise_nxt = (r_rise & ~{N_IN{w_clr_rise}}) | (w_stable_nxt & ~r_stable);
    assign w_fall_nxt = (r_fall & ~{N_IN{w_clr_fall}}) | (~w_stable_nxt & r_stable);

    // Event flag registers.
    always_ff @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    // Zero-extend the per-bit vectors and select the addressed register.
    always_comb begin
        w_stable_ext              = '0;
        w_rise_ext                = '0;
        w_fall_ext                = '0;
        w_stable_ext[N_IN-1:0]    = r_stable;
        w_rise_ext[N_IN-1:0]      = r_rise;
        w_fall_ext[N_IN-1:0]      = r_fall;
        case (addr)
            5'd0:    w_rd_mux = w_stable_ext;
            5'd1:    w_rd_mux = w_rise_ext;
            5'd2:    w_rd_mux = w_fall_ext;
            5'd3:    w_rd_mux = L_NIN_VALUE;
            default: w_rd_mux = 8'h00;
        endcase
    end

    // Read data is captured on rden and held until the next read.
    always_ff @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) begin
            r_rd_data <= 8'h00;
        end else if (rden) begin
            r_rd_data <= w_rd_mux;
        end
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic r_irq;

    // Event-pending flag follows the flags' next-state so it tracks them edge for edge.
    always_ff @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_debounce.sv
// tb/tb_gpio_input_debounce.sv - self-checking bench for gpio_input_debounce
module tb_gpio_input_debounce;

    logic       bus_clk = 1'b0;
    logic       quiesce = 1'b1;
    logic [3:0] pins_in = 4'hF;
    logic       rden    = 1'b0;
    logic [4:0] addr    = 5'd0;
    logic [7:0] rd_data;
    logic [3:0] stable;
    logic       irq;

    int total = 0;
    int bad   = 0;
    bit m_en  = 1'b0;
    bit done  = 1'b0;

    gpio_input_debounce #(
        .N_IN           (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .bus_clk(bus_clk),
        .quiesce(quiesce),
        .pins_in(pins_in),
        .rden   (rden),
        .addr   (addr),
        .rd_data(rd_data),
        .stable (stable),
        .irq    (irq)
    );

    always #5 bus_clk = ~bus_clk;

    // Model: a bit takes a new level once the last four synchronised samples agree on it.
    bit [3:0] h [0:4];
    bit [3:0] m_stable, m_rise, m_fall, m_new;
    bit [7:0] m_rd;
    bit       m_irq;

    initial begin
        forever begin
            @(posedge bus_clk or posedge quiesce);
            if (quiesce) begin
                for (int k = 0; k < 5; k++) h[k] = 4'h0;
                m_stable = 4'h0; m_rise = 4'h0; m_fall = 4'h0; m_rd = 8'h00; m_irq = 1'b0;
            end else begin
                m_new = m_stable;
                for (int i = 0; i < 4; i++) begin
                    if (h[1][i] == h[2][i] && h[2][i] == h[3][i] && h[3][i] == h[4][i]
                        && h[1][i] != m_stable[i])
                        m_new[i] = h[1][i];
                end
                if (rden) begin
                    case (addr)
                        5'd0:    m_rd = {4'h0, m_stable};
                        5'd1:    m_rd = {4'h0, m_rise};
                        5'd2:    m_rd = {4'h0, m_fall};
                        5'd3:    m_rd = 8'h04;
                        default: m_rd = 8'h00;
                    endcase
                end
                m_rise = ((rden && addr == 5'd1) ? 4'h0 : m_rise) | (m_new & ~m_stable);
                m_fall = ((rden && addr == 5'd2) ? 4'h0 : m_fall) | (~m_new & m_stable);
                m_stable = m_new;
                for (int k = 4; k > 0; k--) h[k] = h[k-1];
                h[0] = pins_in;
`ifdef GPIO_DEBOUNCE_IRQ_EN
                m_irq = |(m_rise | m_fall);
`else
                m_irq = 1'b0;
`endif
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        wait (m_en);
        while (!done) begin
            @(negedge bus_clk);
            total++;
            if (stable !== m_stable) begin
                bad++;
                $display("FAIL model_stable t=%0t got=%h exp=%h", $time, stable, m_stable);
            end
            total++;
            if (rd_data !== m_rd) begin
                bad++;
                $display("FAIL model_rd_data t=%0t got=%h exp=%h", $time, rd_data, m_rd);
            end
            total++;
            if (irq !== m_irq) begin
                bad++;
                $display("FAIL model_irq t=%0t got=%b exp=%b", $time, irq, m_irq);
            end
        end
    end

    task automatic tick();
        @(posedge bus_clk);
        @(negedge bus_clk);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input string name, input logic [7:0] exp);
        rden = 1'b1;
        addr = a;
        tick();
        rden = 1'b0;
        check(name, rd_data, exp);
    endtask

    initial begin
        repeat (3) tick();
        m_en = 1'b1;
        check("reset_stable", {4'h0, stable}, 8'h00);
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_irq", {7'h0, irq}, 8'h00);

        // Release with pins high: rise on all bits after six edges.
        #2 quiesce = 1'b0;
        repeat (5) tick();
        check("release_stable_e5", {4'h0, stable}, 8'h00);
        tick();
        check("release_stable_e6", {4'h0, stable}, 8'h0F);
        rd(5'd1, "release_rise", 8'h0F);
        rd(5'd2, "release_fall", 8'h00);

        // Step on bit 0.
        pins_in = 4'hE;
        repeat (10) tick();
        rd(5'd2, "step_pre_fall", 8'h01);
        rd(5'd1, "step_pre_rise", 8'h00);
        pins_in = 4'hF;
        repeat (5) tick();
        check("step_stable_e5", {4'h0, stable}, 8'h0E);
        tick();
        check("step_stable_e6", {4'h0, stable}, 8'h0F);
        rd(5'd1, "step_rise_1", 8'h01);
        rd(5'd1, "step_rise_2", 8'h00);

        // Glitch on bit 2, three cycles long.
        pins_in = 4'hB;
        repeat (10) tick();
        rd(5'd2, "glitch_pre_fall", 8'h04);
        rd(5'd1, "glitch_pre_rise", 8'h00);
        pins_in = 4'hF;
        repeat (3) tick();
        pins_in = 4'hB;
        repeat (10) tick();
        check("glitch_stable", {4'h0, stable}, 8'h0B);
        rd(5'd1, "glitch_rise", 8'h00);
        rd(5'd2, "glitch_fall", 8'h00);

        // Fall on bit 1 in the same edge as a read-clear of the fall flags.
        pins_in = 4'h9;
        repeat (5) tick();
        check("collide_irq_before", {7'h0, irq}, 8'h00);
        rd(5'd2, "collide_read_old", 8'h00);
        check("collide_stable", {4'h0, stable}, 8'h09);
`ifdef GPIO_DEBOUNCE_IRQ_EN
        check("collide_irq_set", {7'h0, irq}, 8'h01);
`else
        check("collide_irq_off", {7'h0, irq}, 8'h00);
`endif
        rd(5'd2, "collide_read_new", 8'h02);
        check("collide_irq_clr", {7'h0, irq}, 8'h00);

        // Register map and hold behaviour.
        rd(5'd0, "map_addr0", 8'h09);
        rd(5'd3, "map_addr3", 8'h04);
        repeat (3) tick();
        check("map_hold", rd_data, 8'h04);
        rd(5'd17, "map_addr17", 8'h00);
        rd(5'd31, "map_addr31", 8'h00);

        // Reset mid-debounce discards the count.
        pins_in = 4'hF;
        repeat (3) tick();
        #2 quiesce = 1'b1;
        tick();
        check("midreset_stable", {4'h0, stable}, 8'h00);
        check("midreset_rd_data", rd_data, 8'h00);
        #2 quiesce = 1'b0;
        repeat (10) tick();
        check("midreset_restable", {4'h0, stable}, 8'h0F);
        rd(5'd1, "midreset_rise", 8'h0F);

        done = 1'b1;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
